// File: rtl/p_bool_mac_seq_pkg.sv
// Shared types for the sequential bool MAC: data-format descriptor, default
// fixed-point format and the engine FSM state encoding.
package p_bool_mac_seq_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] prec;
    } dconf_t;

    localparam dconf_t DEF_DCONF_FXP = '{sign: 1'b1, prec: 8'd16};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/p_bool_mac_seq_if.sv
// Operand/result handshake bundle for p_bool_mac_seq (valid/ready on both sides).
interface p_bool_mac_seq_if #(
    parameter int N       = 16,
    parameter int I2_PREC = 16,
    parameter int O_PREC  = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in1;
    logic [N*I2_PREC-1:0] in2;
    logic                 out_valid;
    logic                 out_ready;
    logic [O_PREC-1:0]    out;
    logic                 out_sat;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out, out_sat
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out, out_sat
    );
endinterface

// File: rtl/p_bool_mac_seq_mult.sv
// Bool-by-weight product: signed mode yields +/-weight (negation wraps in I2_PREC
// bits, then sign-extends); bool mode yields the XNOR match bit zero-extended.
module p_bool_mult
    import p_bool_mac_seq_pkg::*;
#(
    parameter dconf_t I2_CONF = DEF_DCONF_FXP,
    parameter dconf_t O_CONF  = DEF_DCONF_FXP
) (
    input  logic                          i_a,
    input  logic [int'(I2_CONF.prec)-1:0] i_b,
    output logic [int'(O_CONF.prec)-1:0]  o_p
);
    localparam int I2_PREC = int'(I2_CONF.prec);
    localparam int O_PREC  = int'(O_CONF.prec);

    generate
        if (I2_CONF.sign) begin : g_signed
            logic [I2_PREC-1:0] w_neg;
            logic [I2_PREC-1:0] w_sel;
            assign w_neg = -i_b;
            assign w_sel = i_a ? i_b : w_neg;
            assign o_p   = O_PREC'($signed(w_sel));
        end else begin : g_bool
            logic w_eq;
            logic w_unused_b;
            // Only bit 0 of a bool weight carries information.
            assign w_eq       = (i_a == i_b[0]);
            assign w_unused_b = ^i_b;
            assign o_p        = O_PREC'(w_eq);
        end
    endgenerate
endmodule

// File: rtl/p_bool_mac_seq.sv
// Sequential N-step dot product of a bool vector and a weight vector using one
// shared p_bool_mult. Optional per-step saturation via P_BOOL_MAC_SAT_EN.
module p_bool_mac_seq
    import p_bool_mac_seq_pkg::*;
#(
    parameter dconf_t I2_CONF = DEF_DCONF_FXP,
    parameter dconf_t O_CONF  = DEF_DCONF_FXP,
    parameter int     N       = 16
) (
    input  logic           clk,
    input  logic           reset,
    p_bool_mac_seq_if.slave bus
);
    localparam int I2_PREC = int'(I2_CONF.prec);
    localparam int O_PREC  = int'(O_CONF.prec);
    localparam int IW      = idx_width(N);

    state_t               r_state;
    state_t               w_next;
    logic [IW-1:0]        r_idx;
    logic [N-1:0]         r_in1;
    logic [N*I2_PREC-1:0] r_in2;
    logic [O_PREC-1:0]    r_acc;
    logic [O_PREC-1:0]    w_prod;
    logic [O_PREC-1:0]    w_sum;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_a;
    logic [I2_PREC-1:0]   w_b;

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_last   = (r_idx == IW'(N - 1));
    // Shift-based element select keeps N=1 (1-bit index) legal.
    assign w_a      = 1'(r_in1 >> r_idx);
    assign w_b      = I2_PREC'(r_in2 >> (r_idx * I2_PREC));

    p_bool_mult #(
        .I2_CONF(I2_CONF),
        .O_CONF (O_CONF)
    ) u_mult (
        .i_a(w_a),
        .i_b(w_b),
        .o_p(w_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_next = RUN;
            RUN:     if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.out = r_acc;

`ifdef P_BOOL_MAC_SAT_EN
    logic w_clamp;
    logic r_sat;

    generate
        if (I2_CONF.sign) begin : g_ssat
            logic [O_PREC:0] w_wide;
            assign w_wide  = {r_acc[O_PREC-1], r_acc} + {w_prod[O_PREC-1], w_prod};
            // Overflow shows up as disagreement between the two top bits.
            assign w_clamp = w_wide[O_PREC] ^ w_wide[O_PREC-1];
            assign w_sum   = !w_clamp      ? w_wide[O_PREC-1:0] :
                             w_wide[O_PREC] ? {1'b1, {(O_PREC-1){1'b0}}} :
                                              {1'b0, {(O_PREC-1){1'b1}}};
        end else begin : g_usat
            logic [O_PREC:0] w_wide;
            assign w_wide  = {1'b0, r_acc} + {1'b0, w_prod};
            assign w_clamp = w_wide[O_PREC];
            assign w_sum   = w_clamp ? {O_PREC{1'b1}} : w_wide[O_PREC-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)                       r_sat <= 1'b0;
        else if (w_accept)               r_sat <= 1'b0;
        else if (r_state == RUN)         r_sat <= r_sat | w_clamp;
    end

    assign bus.out_sat = r_sat;
`else
    assign w_sum       = r_acc + w_prod;
    assign bus.out_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
            r_acc <= '0;
            r_in1 <= '0;
            r_in2 <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_in1 <= bus.in1;
                    r_in2 <= bus.in2;
                    r_acc <= '0;
                    r_idx <= '0;
                end
                RUN: begin
                    r_acc <= w_sum;
                    if (!w_last) r_idx <= r_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
